dlya_tap_cal_ctrl: RTL and testbench

- Calibration controller for a tapped delay line built from a chain of 5V delay cells (NTAPS taps).
- Selects the delay tap whose output first samples high relative to the reference clock edge; the external sampler is synchronized before it reaches SAMPLE.
- Uses a linear search with settle and majority-vote phases.
- Sits beside the delay chain in the clock/strobe alignment path. Provides software start, busy/done/error status, and a manual tap override.

---
 rtl/dlya_cal_pkg.sv | 15 +
 rtl/dlya_cal_vote.sv | 38 +++
 rtl/dlya_tap_cal_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dlya_tap_cal_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlya_cal_pkg.sv
// Shared state encoding and constants for the delay-line tap calibration controller.
package dlya_cal_pkg;

  typedef logic [2:0] cal_state_e;

  localparam cal_state_e StIdle    = 3'd0;
  localparam cal_state_e StSettle  = 3'd1;
  localparam cal_state_e StMeasure = 3'd2;
  localparam cal_state_e StDecide  = 3'd3;
  localparam cal_state_e StLocked  = 3'd4;
  localparam cal_state_e StFail    = 3'd5;

  localparam int unsigned TRACK_PERIOD = 256;

endpackage

// File: rtl/dlya_cal_vote.sv
// Sample and ones counters for one tap measurement, plus the strict-majority compare.
module dlya_cal_vote
  import dlya_cal_pkg::*;
#(
  parameter int unsigned NSAMP = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic sample,
  output logic done,
  output logic maj
);

  localparam int unsigned CW = $clog2(NSAMP + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] ones_q;
  logic [CW:0]   ones_x2;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (enable) begin
      cnt_q  <= cnt_q + CW'(1);
      ones_q <= ones_q + CW'(sample);
    end
  end

  // done flags the last counted sample so the FSM leaves MEASURE after exactly NSAMP cycles
  assign done    = enable && (cnt_q == CW'(NSAMP - 1));
  assign ones_x2 = {ones_q, 1'b0};
  // A tie is treated as low
  assign maj     = ones_x2 > (CW + 1)'(NSAMP);

endmodule

// File: rtl/dlya_tap_cal_ctrl.sv
// Linear-search tap calibration for a tapped delay line, with manual override.
// Optional continuous tracking while locked is enabled by defining DLYA_CAL_TRACK_EN.
module dlya_tap_cal_ctrl
  import dlya_cal_pkg::*;
#(
  parameter int unsigned NTAPS      = 16,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned NSAMP      = 8,
  parameter int unsigned DEF_TAP    = 0,
  localparam int unsigned TAP_W     = $clog2(NTAPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CAL_START,
  input  logic             SAMPLE,
  input  logic             OVR_EN,
  input  logic [TAP_W-1:0] OVR_TAP,
  output logic [TAP_W-1:0] TAP_SEL,
  output logic             CAL_BUSY,
  output logic             CAL_DONE,
  output logic             CAL_ERR
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TAP_W-1:0] TapMax = TAP_W'(NTAPS - 1);
  localparam logic [TAP_W-1:0] TapDef = TAP_W'(DEF_TAP);

  cal_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             vote_clr, vote_en, vote_done, vote_maj;

`ifdef DLYA_CAL_TRACK_EN
  localparam int unsigned TW = $clog2(TRACK_PERIOD);
  logic          track_q, track_d;
  logic [TW-1:0] trk_cnt_q, trk_cnt_d;
`endif

  dlya_cal_vote #(
    .NSAMP (NSAMP)
  ) u_vote (
    .clk    (CLK),
    .rst    (RST),
    .clear  (vote_clr),
    .enable (vote_en),
    .sample (SAMPLE),
    .done   (vote_done),
    .maj    (vote_maj)
  );

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    vote_clr = 1'b0;
    vote_en  = 1'b0;
`ifdef DLYA_CAL_TRACK_EN
    track_d   = track_q;
    trk_cnt_d = trk_cnt_q;
`endif

    case (state_q)
      StSettle: begin
        vote_clr = 1'b1;
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d = StMeasure;
        else                                 settle_d = settle_q + SW'(1);
      end
      StMeasure: begin
        vote_en = 1'b1;
        if (vote_done) state_d = StDecide;
      end
      StDecide: begin
`ifdef DLYA_CAL_TRACK_EN
        if (track_q) begin
          // Tracking step: nudge one tap toward the transition, clamped at both ends
          state_d = StLocked;
          track_d = 1'b0;
          if (vote_maj) begin
            if (tap_q != '0) tap_d = tap_q - TAP_W'(1);
          end else if (tap_q != TapMax) begin
            tap_d = tap_q + TAP_W'(1);
          end
        end else begin
`else
        begin
`endif
          if (vote_maj) begin
            state_d = StLocked;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (tap_q == TapMax) begin
            state_d = StFail;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            tap_d   = TapDef;
          end else begin
            state_d  = StSettle;
            tap_d    = tap_q + TAP_W'(1);
            settle_d = '0;
          end
        end
      end
      StLocked: begin
`ifdef DLYA_CAL_TRACK_EN
        if (!OVR_EN) begin
          if (trk_cnt_q == TW'(TRACK_PERIOD - 1)) begin
            trk_cnt_d = '0;
            track_d   = 1'b1;
            settle_d  = '0;
            state_d   = StSettle;
          end else begin
            trk_cnt_d = trk_cnt_q + TW'(1);
          end
        end
`endif
      end
      StIdle, StFail: ;
      default: state_d = StIdle;
    endcase

    // Only a full search raises busy, so a start during tracking restarts calibration
    if (CAL_START && !busy_q) begin
      state_d  = StSettle;
      tap_d    = '0;
      settle_d = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      err_d    = 1'b0;
`ifdef DLYA_CAL_TRACK_EN
      track_d   = 1'b0;
      trk_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      tap_q    <= TapDef;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef DLYA_CAL_TRACK_EN
      track_q   <= 1'b0;
      trk_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef DLYA_CAL_TRACK_EN
      track_q   <= track_d;
      trk_cnt_q <= trk_cnt_d;
`endif
    end
  end

  assign TAP_SEL  = OVR_EN ? OVR_TAP : tap_q;
  assign CAL_BUSY = busy_q;
  assign CAL_DONE = done_q;
  assign CAL_ERR  = err_q;

endmodule

// File: tb/tb_dlya_tap_cal_ctrl.sv
// Bench for dlya_tap_cal_ctrl: delay-line model drives SAMPLE, scoreboard holds expected outcomes.
module tb_dlya_tap_cal_ctrl;

  localparam int unsigned TAP_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             CAL_START = 1'b0;
  logic             SAMPLE = 1'b0;
  logic             OVR_EN = 1'b0;
  logic [TAP_W-1:0] OVR_TAP = '0;
  logic [TAP_W-1:0] TAP_SEL;
  logic             CAL_BUSY, CAL_DONE, CAL_ERR;

  typedef struct {
    bit done;
    bit err;
    int tap;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Delay-line model: high at taps >= thr; tap ptap is high for the first hcnt measured samples
  int               thr  = 100;
  int               ptap = -1;
  int               hcnt = 0;
  int               age  = 0;
  logic [TAP_W-1:0] last_tap = '0;

  dlya_tap_cal_ctrl #(
    .NTAPS      (16),
    .SETTLE_CYC (4),
    .NSAMP      (8),
    .DEF_TAP    (0)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CAL_START (CAL_START),
    .SAMPLE    (SAMPLE),
    .OVR_EN    (OVR_EN),
    .OVR_TAP   (OVR_TAP),
    .TAP_SEL   (TAP_SEL),
    .CAL_BUSY  (CAL_BUSY),
    .CAL_DONE  (CAL_DONE),
    .CAL_ERR   (CAL_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (TAP_SEL != last_tap) begin
      age      = 0;
      last_tap = TAP_SEL;
    end else begin
      age++;
    end
    SAMPLE = (int'(TAP_SEL) >= thr) || (int'(TAP_SEL) == ptap && age < 4 + hcnt);
  end

  task automatic pulse_start();
    @(negedge CLK);
    CAL_START = 1'b1;
    @(negedge CLK);
    CAL_START = 1'b0;
  endtask

  task automatic start_cal(input int tap, input bit done, input bit err, input int lat);
    exp_t e;
    e.done = done;
    e.err  = err;
    e.tap  = tap;
    e.lat  = lat;
    sb.push_back(e);
    pulse_start();
    n_tests++;
    if (CAL_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b want 1", CAL_BUSY);
    end
  endtask

  // lat0 is the number of cycles already elapsed since the CAL_START posedge
  task automatic wait_result(input int lat0, input string name);
    int   lat;
    exp_t e;
    lat = lat0;
    while (!(CAL_DONE === 1'b1 || CAL_ERR === 1'b1) && lat < 600) begin
      @(negedge CLK);
      lat++;
    end
    e = sb.pop_front();
    n_tests++;
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    n_tests++;
    if (CAL_DONE !== e.done || CAL_ERR !== e.err) begin
      n_fail++;
      $display("FAIL %s flags: got done=%b err=%b want done=%b err=%b",
               name, CAL_DONE, CAL_ERR, e.done, e.err);
    end
    n_tests++;
    if (int'(TAP_SEL) !== e.tap) begin
      n_fail++;
      $display("FAIL %s tap: got %0d want %0d", name, TAP_SEL, e.tap);
    end
    n_tests++;
    if (CAL_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_end: got %b want 0", name, CAL_BUSY);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    n_tests++;
    if (TAP_SEL !== 4'd0 || CAL_BUSY !== 1'b0 || CAL_DONE !== 1'b0 || CAL_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got tap=%0d busy=%b done=%b err=%b want 0 0 0 0",
               TAP_SEL, CAL_BUSY, CAL_DONE, CAL_ERR);
    end
  endtask

  task automatic test_lock_tap5();
    thr = 5; ptap = -1;
    start_cal(5, 1'b1, 1'b0, 79);
    wait_result(1, "lock_tap5");
  endtask

  task automatic test_majority();
    thr = 4; ptap = 3; hcnt = 4;
    start_cal(4, 1'b1, 1'b0, 66);
    wait_result(1, "maj_tie");
    hcnt = 5;
    start_cal(3, 1'b1, 1'b0, 53);
    wait_result(1, "maj_5of8");
    ptap = -1;
  endtask

  task automatic test_no_transition();
    thr = 100;
    start_cal(0, 1'b0, 1'b1, 209);
    wait_result(1, "no_transition");
  endtask

  task automatic test_back_to_back();
    thr = 0;
    start_cal(0, 1'b1, 1'b0, 14);
    wait_result(1, "restart_from_fail");
    thr = 2;
    start_cal(2, 1'b1, 1'b0, 40);
    wait_result(1, "restart_from_lock");
  endtask

  task automatic test_ignore_start();
    thr = 5;
    start_cal(5, 1'b1, 1'b0, 79);
    repeat (19) @(negedge CLK);
    CAL_START = 1'b1;
    @(negedge CLK);
    CAL_START = 1'b0;
    wait_result(21, "ignore_start");
  endtask

  task automatic test_abort();
    thr = 5;
    pulse_start();
    repeat (39) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_tests++;
    if (TAP_SEL !== 4'd0 || CAL_BUSY !== 1'b0 || CAL_DONE !== 1'b0 || CAL_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got tap=%0d busy=%b done=%b err=%b want 0 0 0 0",
               TAP_SEL, CAL_BUSY, CAL_DONE, CAL_ERR);
    end
    repeat (20) @(negedge CLK);
    n_tests++;
    if (TAP_SEL !== 4'd0 || CAL_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got tap=%0d busy=%b want 0 0", TAP_SEL, CAL_BUSY);
    end
  endtask

  task automatic test_override();
    thr = 100;
    start_cal(0, 1'b0, 1'b1, 209);
    repeat (4) @(negedge CLK);
    OVR_TAP = 4'd9;
    OVR_EN  = 1'b1;
    #1;
    n_tests++;
    if (TAP_SEL !== 4'd9 || CAL_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL override: got tap=%0d busy=%b want 9 1", TAP_SEL, CAL_BUSY);
    end
    repeat (95) @(negedge CLK);
    OVR_EN = 1'b0;
    wait_result(100, "override_progress");
  endtask

`ifdef DLYA_CAL_TRACK_EN
  task automatic test_tracking();
    int n;
    thr = 5;
    start_cal(5, 1'b1, 1'b0, 79);
    wait_result(1, "track_lock");
    thr = 100;
    n = 0;
    while (TAP_SEL !== 4'd6 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    n_tests++;
    if (n !== 269 || CAL_DONE !== 1'b1 || CAL_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL tracking: got cycles=%0d tap=%0d done=%b busy=%b want 269 6 1 0",
               n, TAP_SEL, CAL_DONE, CAL_BUSY);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_tap5();
    test_majority();
    test_no_transition();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_override();
`ifdef DLYA_CAL_TRACK_EN
    test_tracking();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
